piradspi_target: RTL and testbench

SPI target (peripheral) endpoint; the far end of the PiRadSPI controller engine.
- Oversamples the external sclk/mosi/csn in the aclk domain.
- Deserialises mosi into AXI-Stream words with frame-boundary tlast.
- Serialises AXI-Stream words onto miso.
- Used for loopback verification of the controller and for FPGA-as-peripheral designs.

---
 rtl/piradspi_target.sv | 251 +++++++++++++++++++++++++
 tb/tb_piradspi_target.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/piradspi_target.sv
// piradspi_target: SPI peripheral endpoint, oversampled in the aclk domain.
// Latency: miso/busy/miso_oe move 3 aclk after the physical sclk/csn edge; rx words leave via a 2-deep pending/output stage.
// Backpressure: m_tready low holds the output word; further completed words are dropped with an overflow pulse.
module piradspi_target #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter bit                    CPOL       = 1'b0,
  parameter bit                    CPHA       = 1'b0,
  parameter bit                    MSB_FIRST  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  csn,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  overflow,
  output logic                  underrun,
  output logic                  frame_err
);

  localparam int unsigned     CNT_W      = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [0:0]      ST_IDLE    = 1'b0;
  localparam logic [0:0]      ST_ACTIVE  = 1'b1;
  localparam logic            FILL_FIRST = MSB_FIRST ? FILL_WORD[DATA_WIDTH-1] : FILL_WORD[0];

  // Bit that goes on the wire first for a given word.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  // Word with its first-on-wire bit removed, so the next bit sits in the first position.
  function automatic logic [DATA_WIDTH-1:0] drop_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  // Synchroniser stages plus one history flop for edge detection.
  logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic mosi_s1_q, mosi_s2_q;
  logic csn_s1_q, csn_s2_q, csn_prev_q;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  miso_q, miso_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
  logic                  out_vld_q, out_vld_d;
  logic                  out_last_q, out_last_d;
  logic                  s_tready_q, s_tready_d;
  logic                  underrun_q, underrun_d;
  logic                  overflow_q, overflow_d;
  logic                  frame_err_q, frame_err_d;

  logic                  act, csn_fall, csn_rise, sclk_chg;
  logic                  lead_evt, trail_evt, sample_evt, shift_evt;
  logic                  tx_load, word_done;
  logic [CNT_W-1:0]      bit_cnt_adv;
  logic [DATA_WIDTH-1:0] rx_next, tx_word;

  // 2-FF synchronisers for the asynchronous SPI pins, idle-level reset values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sclk_s1_q   <= CPOL;
      sclk_s2_q   <= CPOL;
      sclk_prev_q <= CPOL;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      csn_s1_q    <= 1'b1;
      csn_s2_q    <= 1'b1;
      csn_prev_q  <= 1'b1;
    end else begin
      sclk_s1_q   <= sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      mosi_s1_q   <= mosi;
      mosi_s2_q   <= mosi_s1_q;
      csn_s1_q    <= csn;
      csn_s2_q    <= csn_s1_q;
      csn_prev_q  <= csn_s2_q;
    end
  end

  // Edge classification; sclk edges count only once ACTIVE is already registered,
  // so an edge landing on the csn-fall cycle or while idle is ignored.
  always_comb begin
    act        = (state_q == ST_ACTIVE);
    csn_fall   = csn_prev_q & ~csn_s2_q;
    csn_rise   = ~csn_prev_q & csn_s2_q;
    sclk_chg   = act & (sclk_s2_q ^ sclk_prev_q);
    lead_evt   = sclk_chg & (sclk_s2_q != CPOL);
    trail_evt  = sclk_chg & (sclk_s2_q == CPOL);
    sample_evt = CPHA ? trail_evt : lead_evt;
    shift_evt  = CPHA ? lead_evt : trail_evt;
  end

  // Select FSM: IDLE until csn falls, ACTIVE until csn rises.
  always_comb begin
    state_d = state_q;
    if (!act && csn_fall) begin
      state_d = ST_ACTIVE;
    end else if (act && csn_rise) begin
      state_d = ST_IDLE;
    end
  end

  // Tx serialiser: a load takes the stream word (or the fill word) and presents its first bit;
  // every other shift edge advances one bit. bit_cnt==0 on a shift edge marks a word boundary.
  always_comb begin
    tx_word    = s_tvalid ? s_tdata : FILL_WORD;
    tx_load    = CPHA ? (shift_evt && (bit_cnt_q == '0))
                      : ((!act && csn_fall) || (shift_evt && (bit_cnt_q == '0)));
    tx_shift_d = tx_shift_q;
    miso_d     = miso_q;
    s_tready_d = 1'b0;
    underrun_d = 1'b0;
    if (tx_load) begin
      miso_d     = first_bit(tx_word);
      tx_shift_d = drop_bit(tx_word);
      s_tready_d = s_tvalid;
      underrun_d = ~s_tvalid;
    end else if (shift_evt) begin
      miso_d     = first_bit(tx_shift_q);
      tx_shift_d = drop_bit(tx_shift_q);
    end
  end

  // Rx deserialiser: sample edges shift mosi in; csn edges throw away any partial word.
  always_comb begin
    rx_next     = MSB_FIRST ? {rx_shift_q[DATA_WIDTH-2:0], mosi_s2_q}
                            : {mosi_s2_q, rx_shift_q[DATA_WIDTH-1:1]};
    word_done   = sample_evt && (bit_cnt_q == LAST_BIT);
    bit_cnt_adv = bit_cnt_q;
    if (sample_evt) begin
      bit_cnt_adv = word_done ? '0 : bit_cnt_q + 1'b1;
    end
    frame_err_d = act && csn_rise && (bit_cnt_adv != '0);
    if (csn_fall || (act && csn_rise)) begin
      bit_cnt_d  = '0;
      rx_shift_d = '0;
    end else begin
      bit_cnt_d  = bit_cnt_adv;
      rx_shift_d = sample_evt ? rx_next : rx_shift_q;
    end
  end

  // Pending/output stage. A completed word waits in pending until either another word
  // completes (then it leaves with tlast=0) or csn rises (then it leaves with tlast=1).
  // A word completing on the csn-rise cycle is parked first, so it is the one tagged last.
  always_comb begin
    logic out_free, out_load;
    out_free   = !out_vld_q || m_tready;
    out_load   = 1'b0;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    out_dat_d  = out_dat_q;
    out_last_d = out_last_q;
    overflow_d = 1'b0;
    if (word_done) begin
      if (pend_vld_d) begin
        if (out_free) begin
          out_load   = 1'b1;
          out_dat_d  = pend_d;
          out_last_d = 1'b0;
        end else begin
          overflow_d = 1'b1;
        end
      end
      pend_d     = rx_next;
      pend_vld_d = 1'b1;
    end
    if (act && csn_rise) begin
      if (pend_vld_d) begin
        if (out_free && !out_load) begin
          out_load   = 1'b1;
          out_dat_d  = pend_d;
          out_last_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      pend_vld_d = 1'b0;
    end
    if (out_load) begin
      out_vld_d = 1'b1;
    end else if (out_vld_q && m_tready) begin
      out_vld_d = 1'b0;
    end else begin
      out_vld_d = out_vld_q;
    end
  end

  // Core state registers; reset returns everything to idle immediately.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      miso_q      <= FILL_FIRST;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      out_dat_q   <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      s_tready_q  <= 1'b0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      out_dat_q   <= out_dat_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
      s_tready_q  <= s_tready_d;
      underrun_q  <= underrun_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = (state_q == ST_ACTIVE);
  assign busy      = (state_q == ST_ACTIVE);
  assign s_tready  = s_tready_q;
  assign m_tdata   = out_dat_q;
  assign m_tvalid  = out_vld_q;
  assign m_tlast   = out_last_q;
  assign overflow  = overflow_q;
  assign underrun  = underrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_piradspi_target.sv
// tb_piradspi_target: directed bench with two targets, mode 0 MSB-first (fill 0xFF)
// and CPOL=1/CPHA=1 LSB-first (fill 0x00), each driven by a bit-banged controller.
// Pulses and stream beats are tallied on the falling aclk edge.
module tb_piradspi_target;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic       aresetn;
  logic [1:0] sclk, mosi, csn, miso, miso_oe;
  logic [1:0] s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
  logic [1:0] busy, overflow, underrun, frame_err;
  logic [7:0] s_tdata [2];
  logic [7:0] m_tdata [2];

  piradspi_target #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .FILL_WORD(8'hFF)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .sclk(sclk[0]), .mosi(mosi[0]), .csn(csn[0]),
    .miso(miso[0]), .miso_oe(miso_oe[0]), .s_tdata(s_tdata[0]), .s_tvalid(s_tvalid[0]),
    .s_tready(s_tready[0]), .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]),
    .m_tlast(m_tlast[0]), .busy(busy[0]), .overflow(overflow[0]), .underrun(underrun[0]),
    .frame_err(frame_err[0]));

  piradspi_target #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .FILL_WORD(8'h00)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .sclk(sclk[1]), .mosi(mosi[1]), .csn(csn[1]),
    .miso(miso[1]), .miso_oe(miso_oe[1]), .s_tdata(s_tdata[1]), .s_tvalid(s_tvalid[1]),
    .s_tready(s_tready[1]), .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]),
    .m_tlast(m_tlast[1]), .busy(busy[1]), .overflow(overflow[1]), .underrun(underrun[1]),
    .frame_err(frame_err[1]));

  int         n_chk = 0;
  int         n_err = 0;
  int         n_rdy [2] = '{0, 0};
  int         n_und [2] = '{0, 0};
  int         n_ovf [2] = '{0, 0};
  int         n_ferr[2] = '{0, 0};
  logic [8:0] beats0[$];
  logic [8:0] beats1[$];
  logic [7:0] tx_w[3];
  logic [7:0] rx_w[3];

  // Pulse tallies and accepted beats, sampled away from the rising edge.
  always @(negedge aclk) begin
    for (int i = 0; i < 2; i++) begin
      if (s_tready[i])  n_rdy[i]++;
      if (underrun[i])  n_und[i]++;
      if (overflow[i])  n_ovf[i]++;
      if (frame_err[i]) n_ferr[i]++;
    end
    if (m_tvalid[0] && m_tready[0]) beats0.push_back({m_tlast[0], m_tdata[0]});
    if (m_tvalid[1] && m_tready[1]) beats1.push_back({m_tlast[1], m_tdata[1]});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Controller model: sends tx_w[0..nw-1], last word truncated to 'cut' bits, captures miso into rx_w.
  // In mode 0 the closing sclk edge is issued after csn has risen.
  task automatic spi_frame(input int d, input int nw, input int cut);
    logic cp, ph, mf;
    int   nb, bi;
    cp = (d == 1);
    ph = (d == 1);
    mf = (d == 0);
    csn[d] = 1'b0;
    wait_cyc(6);
    for (int w = 0; w < nw; w++) begin
      rx_w[w] = 8'h00;
      nb = (w == nw - 1) ? cut : 8;
      for (int b = 0; b < nb; b++) begin
        bi = mf ? 7 - b : b;
        if (!ph) begin
          mosi[d] = tx_w[w][bi];
          wait_cyc(4);
          rx_w[w][bi] = miso[d];
          sclk[d] = ~cp;
          wait_cyc(4);
          if (!(w == nw - 1 && b == nb - 1)) sclk[d] = cp;
        end else begin
          sclk[d] = ~cp;
          mosi[d] = tx_w[w][bi];
          wait_cyc(4);
          rx_w[w][bi] = miso[d];
          sclk[d] = cp;
          wait_cyc(4);
        end
      end
    end
    csn[d] = 1'b1;
    wait_cyc(4);
    sclk[d] = cp;
    wait_cyc(8);
  endtask

  initial begin
    int b0, b1, r0, u0, o0, f0, r1;
    aresetn  = 1'b0;
    sclk     = 2'b10;
    mosi     = 2'b00;
    csn      = 2'b11;
    s_tvalid = 2'b00;
    m_tready = 2'b11;
    s_tdata[0] = 8'h00;
    s_tdata[1] = 8'h00;
    wait_cyc(3);

    // Reset state.
    chk("rst_miso", {30'd0, miso}, 32'h1);
    chk("rst_oe_busy", {28'd0, miso_oe, busy}, 32'h0);
    chk("rst_stream", {26'd0, m_tvalid, m_tlast, s_tready}, 32'h0);
    chk("rst_pulses", {26'd0, overflow, underrun, frame_err}, 32'h0);
    aresetn = 1'b1;
    wait_cyc(4);

    // Single byte, mode 0: tx 0x3C, rx 0xA5.
    b0 = beats0.size(); r0 = n_rdy[0]; u0 = n_und[0];
    s_tdata[0] = 8'h3C; s_tvalid[0] = 1'b1;
    tx_w[0] = 8'hA5;
    spi_frame(0, 1, 8);
    s_tvalid[0] = 1'b0;
    wait_cyc(2);
    chk("t1_miso_word", {24'd0, rx_w[0]}, 32'h3C);
    chk("t1_beats", beats0.size() - b0, 1);
    chk("t1_beat0", {23'd0, beats0[b0]}, 32'h1A5);
    chk("t1_tready", n_rdy[0] - r0, 1);
    chk("t1_underrun", n_und[0] - u0, 0);

    // Three-byte frame, no backpressure.
    b0 = beats0.size(); o0 = n_ovf[0]; u0 = n_und[0];
    tx_w[0] = 8'h01; tx_w[1] = 8'h02; tx_w[2] = 8'h03;
    spi_frame(0, 3, 8);
    chk("t2_beats", beats0.size() - b0, 3);
    chk("t2_beat0", {23'd0, beats0[b0]}, 32'h001);
    chk("t2_beat1", {23'd0, beats0[b0+1]}, 32'h002);
    chk("t2_beat2", {23'd0, beats0[b0+2]}, 32'h103);
    chk("t2_overflow", n_ovf[0] - o0, 0);
    chk("t2_underrun", n_und[0] - u0, 3);

    // Empty tx stream: fill word on miso, one underrun per word.
    u0 = n_und[0];
    tx_w[0] = 8'h11; tx_w[1] = 8'h22;
    spi_frame(0, 2, 8);
    chk("t3_miso0", {24'd0, rx_w[0]}, 32'hFF);
    chk("t3_miso1", {24'd0, rx_w[1]}, 32'hFF);
    chk("t3_underrun", n_und[0] - u0, 2);

    // Downstream stalled for the whole frame.
    b0 = beats0.size(); o0 = n_ovf[0];
    m_tready[0] = 1'b0;
    tx_w[0] = 8'h01; tx_w[1] = 8'h02; tx_w[2] = 8'h03;
    spi_frame(0, 3, 8);
    chk("t4_hold_vld", {31'd0, m_tvalid[0]}, 32'h1);
    chk("t4_hold_dat", {24'd0, m_tdata[0]}, 32'h01);
    chk("t4_hold_last", {31'd0, m_tlast[0]}, 32'h0);
    chk("t4_overflow", n_ovf[0] - o0, 2);
    m_tready[0] = 1'b1;
    wait_cyc(4);
    chk("t4_beats", beats0.size() - b0, 1);
    chk("t4_beat0", {23'd0, beats0[b0]}, 32'h001);
    chk("t4_drained", {31'd0, m_tvalid[0]}, 32'h0);

    // CPOL=1, CPHA=1, LSB first: tx 0x81, rx 0x5A.
    b1 = beats1.size(); r1 = n_rdy[1];
    s_tdata[1] = 8'h81; s_tvalid[1] = 1'b1;
    tx_w[0] = 8'h5A;
    spi_frame(1, 1, 8);
    s_tvalid[1] = 1'b0;
    wait_cyc(2);
    chk("t5_miso_word", {24'd0, rx_w[0]}, 32'h81);
    chk("t5_beats", beats1.size() - b1, 1);
    chk("t5_beat0", {23'd0, beats1[b1]}, 32'h15A);
    chk("t5_tready", n_rdy[1] - r1, 1);

    // csn rises 5 bits into the second byte.
    b0 = beats0.size(); f0 = n_ferr[0];
    tx_w[0] = 8'hAA; tx_w[1] = 8'h55;
    spi_frame(0, 2, 5);
    chk("t6_beats", beats0.size() - b0, 1);
    chk("t6_beat0", {23'd0, beats0[b0]}, 32'h1AA);
    chk("t6_frame_err", n_ferr[0] - f0, 1);

    // Reset asserted in the middle of the next frame.
    csn[0] = 1'b0;
    wait_cyc(8);
    chk("t7_busy_pre", {30'd0, miso_oe[0], busy[0]}, 32'h3);
    mosi[0] = 1'b1;
    sclk[0] = 1'b1;
    wait_cyc(2);
    aresetn = 1'b0;
    #2;
    chk("t7_oe_busy", {30'd0, miso_oe[0], busy[0]}, 32'h0);
    chk("t7_stream", {29'd0, m_tvalid[0], m_tlast[0], s_tready[0]}, 32'h0);
    chk("t7_pulses", {29'd0, overflow[0], underrun[0], frame_err[0]}, 32'h0);
    chk("t7_miso", {31'd0, miso[0]}, 32'h1);
    csn[0]  = 1'b1;
    sclk[0] = 1'b0;
    mosi[0] = 1'b0;
    wait_cyc(3);
    aresetn = 1'b1;
    wait_cyc(6);
    chk("t7_idle_after", {30'd0, miso_oe[0], busy[0]}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
